// File: rtl/stage_3_ex_pkg.sv
// Shared types and constants for the execute stage: bus widths, ALU op bit
// positions and the packed layouts of the decode->execute and execute->memory buses.
package stage_3_ex_pkg;

  localparam int DS_BUS_W = 117;
  localparam int ES_BUS_W = 71;
  localparam int ALU_OP_W = 12;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLT  = 4'd2,
    OP_SLTU = 4'd3,
    OP_AND  = 4'd4,
    OP_NOR  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_SRA  = 4'd10,
    OP_LUI  = 4'd11
  } alu_op_e;

  // Field order is MSB first and must match decode's packing exactly.
  typedef struct packed {
    logic                rfWe;
    logic [4:0]          dest;
    logic                resFromMem;
    logic [31:0]         src1;
    logic [31:0]         src2;
    logic [ALU_OP_W-1:0] aluOp;
    logic                memWe;
    logic                memEn;
    logic [31:0]         pc;
  } ds_bus_t;

  typedef struct packed {
    logic        rfWe;
    logic [4:0]  dest;
    logic        resFromMem;
    logic [31:0] aluResult;
    logic [31:0] pc;
  } es_bus_t;

  // Decode's hazard check reads register 0 as "nobody is writing".
  function automatic logic [4:0] fwdTag(input logic valid, input logic rfWe, input logic [4:0] dest);
    return (valid && rfWe) ? dest : 5'd0;
  endfunction

endpackage

// File: rtl/stage_3_ex_if.sv
// Handshake and bus signals around the execute stage; the master side is the
// execute stage itself, the slave side is its decode/memory/SRAM environment.
interface stage_3_ex_if;
  import stage_3_ex_pkg::*;

  logic                valid_2;
  logic                allow_3;
  logic                valid_3;
  logic                allow_4;
  logic [DS_BUS_W-1:0] stage_2_to_3;
  logic [31:0]         memory_write_data;
  logic [ES_BUS_W-1:0] stage_3_to_4;
  logic                data_sram_en;
  logic [3:0]          data_sram_we;
  logic [31:0]         data_sram_addr;
  logic [31:0]         data_sram_wdata;
  logic [4:0]          rf_waddr_3_fwd;

  modport master (
    input  valid_2, allow_4, stage_2_to_3, memory_write_data,
    output allow_3, valid_3, stage_3_to_4, data_sram_en, data_sram_we,
           data_sram_addr, data_sram_wdata, rf_waddr_3_fwd
  );

  modport slave (
    output valid_2, allow_4, stage_2_to_3, memory_write_data,
    input  allow_3, valid_3, stage_3_to_4, data_sram_en, data_sram_we,
           data_sram_addr, data_sram_wdata, rf_waddr_3_fwd
  );

endinterface

// File: rtl/stage_3_ex_alu.sv
// Combinational 12-op ALU driven by a one-hot op vector; an all-zero op yields zero.
module stage_3_ex_alu
  import stage_3_ex_pkg::*;
(
  input  logic [31:0]         i_src1,
  input  logic [31:0]         i_src2,
  input  logic [ALU_OP_W-1:0] i_aluOp,
  output logic [31:0]         o_aluResult
);

  logic [4:0]  w_shamt;
  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic        w_lt;
  logic        w_ltu;
  logic [31:0] w_sra;

  assign w_shamt = i_src2[4:0];
  assign w_sum   = i_src1 + i_src2;
  assign w_diff  = i_src1 - i_src2;
  assign w_lt    = $signed(i_src1) < $signed(i_src2);
  assign w_ltu   = i_src1 < i_src2;
  assign w_sra   = $signed(i_src1) >>> w_shamt;

  // Each op's result is masked by its one-hot bit and OR-merged, so no priority chain.
  always_comb begin
    o_aluResult = 32'd0;
    o_aluResult |= {32{i_aluOp[OP_ADD]}}  & w_sum;
    o_aluResult |= {32{i_aluOp[OP_SUB]}}  & w_diff;
    o_aluResult |= {32{i_aluOp[OP_SLT]}}  & {31'd0, w_lt};
    o_aluResult |= {32{i_aluOp[OP_SLTU]}} & {31'd0, w_ltu};
    o_aluResult |= {32{i_aluOp[OP_AND]}}  & (i_src1 & i_src2);
    o_aluResult |= {32{i_aluOp[OP_NOR]}}  & ~(i_src1 | i_src2);
    o_aluResult |= {32{i_aluOp[OP_OR]}}   & (i_src1 | i_src2);
    o_aluResult |= {32{i_aluOp[OP_XOR]}}  & (i_src1 ^ i_src2);
    o_aluResult |= {32{i_aluOp[OP_SLL]}}  & (i_src1 << w_shamt);
    o_aluResult |= {32{i_aluOp[OP_SRL]}}  & (i_src1 >> w_shamt);
    o_aluResult |= {32{i_aluOp[OP_SRA]}}  & w_sra;
    o_aluResult |= {32{i_aluOp[OP_LUI]}}  & i_src2;
  end

endmodule

// File: rtl/stage_3_ex.sv
// Execute stage: latches the decode bus, runs the ALU and issues the data-SRAM
// request in the cycle the instruction hands off to the memory stage.
module stage_3_ex
  import stage_3_ex_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  stage_3_ex_if.master pipe
);

  logic        r_valid3;
  ds_bus_t     r_payload;
  logic [31:0] r_storeData;

  logic        w_readyGo3;
  logic        w_allow3;
  logic        w_handoff;
  logic [31:0] w_aluResult;
  es_bus_t     w_esBus;

  assign w_readyGo3 = 1'b1;
  assign w_allow3   = ~r_valid3 | (w_readyGo3 & pipe.allow_4);
  assign w_handoff  = r_valid3 & w_readyGo3 & pipe.allow_4;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid3 <= 1'b0;
    end else if (w_allow3) begin
      r_valid3 <= pipe.valid_2;
    end
  end

  // Payload holds across stalls and after the instruction leaves.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_payload   <= '0;
      r_storeData <= 32'd0;
    end else if (pipe.valid_2 && w_allow3) begin
      r_payload   <= ds_bus_t'(pipe.stage_2_to_3);
      r_storeData <= pipe.memory_write_data;
    end
  end

  stage_3_ex_alu u_alu (
    .i_src1      (r_payload.src1),
    .i_src2      (r_payload.src2),
    .i_aluOp     (r_payload.aluOp),
    .o_aluResult (w_aluResult)
  );

  assign w_esBus.rfWe       = r_payload.rfWe;
  assign w_esBus.dest       = r_payload.dest;
  assign w_esBus.resFromMem = r_payload.resFromMem;
  assign w_esBus.aluResult  = w_aluResult;
  assign w_esBus.pc         = r_payload.pc;

  assign pipe.allow_3      = w_allow3;
  assign pipe.valid_3      = r_valid3;
  assign pipe.stage_3_to_4 = w_esBus;

  // Gating with the handoff keeps a stalled access from being issued more than once.
  assign pipe.data_sram_en    = w_handoff & r_payload.memEn;
  assign pipe.data_sram_we    = {4{w_handoff & r_payload.memWe}};
  assign pipe.data_sram_addr  = w_aluResult;
  assign pipe.data_sram_wdata = r_storeData;
  assign pipe.rf_waddr_3_fwd  = fwdTag(r_valid3, r_payload.rfWe, r_payload.dest);

endmodule

// File: tb/tb_stage_3_ex.sv
// Self-checking bench for stage_3_ex: directed scenarios followed by random
// traffic, all compared against a behavioural model of the stage.
module tb_stage_3_ex;

  logic clk;
  logic reset;

  stage_3_ex_if ifc ();

  stage_3_ex dut (
    .clk   (clk),
    .reset (reset),
    .pipe  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;
  int enCount;

  logic        iReset, iValid2, iAllow4;
  logic        iRfWe, iRfm, iMemWe, iMemEn;
  logic [4:0]  iDest;
  logic [31:0] iSrc1, iSrc2, iPc, iWdata;
  logic [11:0] iOp;

  logic        mValid;
  logic        mRfWe, mRfm, mMemWe, mMemEn;
  logic [4:0]  mDest;
  logic [31:0] mSrc1, mSrc2, mPc, mWdata;
  logic [11:0] mOp;

  function automatic logic [31:0] aluRef(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      12'h001: return a + b;
      12'h002: return a - b;
      12'h004: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      12'h008: return (a < b) ? 32'd1 : 32'd0;
      12'h010: return a & b;
      12'h020: return ~(a | b);
      12'h040: return a | b;
      12'h080: return a ^ b;
      12'h100: return a << sh;
      12'h200: return a >> sh;
      12'h400: return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      12'h800: return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    reset                 = iReset;
    ifc.valid_2           = iValid2;
    ifc.allow_4           = iAllow4;
    ifc.stage_2_to_3      = {iRfWe, iDest, iRfm, iSrc1, iSrc2, iOp, iMemWe, iMemEn, iPc};
    ifc.memory_write_data = iWdata;
  endtask

  task automatic setInstr(input logic rfWe, input logic [4:0] dest, input logic [31:0] src1,
                          input logic [31:0] src2, input int opIdx, input logic memWe,
                          input logic memEn, input logic [31:0] pc, input logic [31:0] wdata);
    iRfWe  = rfWe;
    iDest  = dest;
    iRfm   = memEn & ~memWe;
    iSrc1  = src1;
    iSrc2  = src2;
    iOp    = 12'h000;
    if (opIdx < 12) iOp[opIdx] = 1'b1;
    iMemWe = memWe;
    iMemEn = memEn;
    iPc    = pc;
    iWdata = wdata;
  endtask

  task automatic updateModel();
    logic canTake;
    canTake = !mValid || iAllow4;
    if (iReset) begin
      mValid = 0; mRfWe = 0; mRfm = 0; mMemWe = 0; mMemEn = 0;
      mDest = 0; mSrc1 = 0; mSrc2 = 0; mPc = 0; mWdata = 0; mOp = 0;
    end else if (canTake) begin
      if (iValid2) begin
        mRfWe = iRfWe; mDest = iDest; mRfm = iRfm; mSrc1 = iSrc1; mSrc2 = iSrc2;
        mOp = iOp; mMemWe = iMemWe; mMemEn = iMemEn; mPc = iPc; mWdata = iWdata;
      end
      mValid = iValid2;
    end
  endtask

  task automatic checkAll();
    logic [31:0] expAlu;
    logic        fire;
    expAlu = aluRef(mOp, mSrc1, mSrc2);
    fire   = mValid && iAllow4;
    checkOutput("valid_3", ifc.valid_3, mValid);
    checkOutput("allow_3", ifc.allow_3, !mValid || iAllow4);
    checkOutput("stage_3_to_4", ifc.stage_3_to_4, {mRfWe, mDest, mRfm, expAlu, mPc});
    checkOutput("sram_en", ifc.data_sram_en, fire && mMemEn);
    checkOutput("sram_we", ifc.data_sram_we, {4{fire && mMemWe}});
    checkOutput("sram_addr", ifc.data_sram_addr, expAlu);
    checkOutput("sram_wdata", ifc.data_sram_wdata, mWdata);
    checkOutput("fwd", ifc.rf_waddr_3_fwd, (mValid && mRfWe) ? mDest : 5'd0);
    if (ifc.data_sram_en === 1'b1) enCount++;
  endtask

  task automatic runCycle();
    applyStimulus();
    #1 checkAll();
    @(posedge clk);
    updateModel();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests = 0; fails = 0; enCount = 0;
    mValid = 0; mRfWe = 0; mRfm = 0; mMemWe = 0; mMemEn = 0;
    mDest = 0; mSrc1 = 0; mSrc2 = 0; mPc = 0; mWdata = 0; mOp = 0;
    iReset = 1; iValid2 = 0; iAllow4 = 0;
    setInstr(0, 0, 0, 0, 12, 0, 0, 0, 0);
    applyStimulus();

    // 1: reset held for two cycles
    repeat (2) begin @(posedge clk); updateModel(); end
    @(negedge clk);
    checkOutput("rst_valid_3", ifc.valid_3, 1'b0);
    checkOutput("rst_allow_3", ifc.allow_3, 1'b1);
    checkOutput("rst_sram_en", ifc.data_sram_en, 1'b0);
    checkOutput("rst_sram_we", ifc.data_sram_we, 4'h0);
    checkOutput("rst_fwd", ifc.rf_waddr_3_fwd, 5'd0);
    checkOutput("rst_bus", ifc.stage_3_to_4, 71'd0);
    iReset = 0;

    // 2: add overflow wrap, slt and sltu
    iAllow4 = 1; iValid2 = 1;
    setInstr(1, 5, 32'h7FFF_FFFF, 32'h1, 0, 0, 0, 32'h0000_1000, 0);
    runCycle();
    checkOutput("add_valid", ifc.valid_3, 1'b1);
    checkOutput("add_result", ifc.stage_3_to_4[63:32], 32'h8000_0000);
    checkOutput("add_fwd", ifc.rf_waddr_3_fwd, 5'd5);
    setInstr(1, 6, 32'h7FFF_FFFF, 32'h1, 2, 0, 0, 32'h0000_1004, 0);
    runCycle();
    checkOutput("slt_result", ifc.stage_3_to_4[63:32], 32'h0);
    setInstr(1, 7, 32'hFFFF_FFFF, 32'h1, 3, 0, 0, 32'h0000_1008, 0);
    runCycle();
    checkOutput("sltu_result", ifc.stage_3_to_4[63:32], 32'h0);

    // 3: shifts and lui
    setInstr(1, 8, 32'h8000_0000, 32'h24, 10, 0, 0, 32'h0000_100C, 0);
    runCycle();
    checkOutput("sra_result", ifc.stage_3_to_4[63:32], 32'hF800_0000);
    setInstr(1, 8, 32'h8000_0000, 32'h24, 9, 0, 0, 32'h0000_1010, 0);
    runCycle();
    checkOutput("srl_result", ifc.stage_3_to_4[63:32], 32'h0800_0000);
    setInstr(1, 9, 32'h0, 32'h1234_5000, 11, 0, 0, 32'h0000_1014, 0);
    runCycle();
    checkOutput("lui_result", ifc.stage_3_to_4[63:32], 32'h1234_5000);

    // 4: store stalled for three cycles, then released
    iValid2 = 1; iAllow4 = 1;
    setInstr(0, 0, 32'h0000_2000, 32'h8, 0, 1, 1, 32'h0000_0100, 32'hDEAD_BEEF);
    runCycle();
    enCount = 0;
    iAllow4 = 0;
    setInstr(1, 4, 32'h1, 32'h2, 0, 0, 0, 32'h0000_0104, 32'h0);
    for (int s = 0; s < 3; s++) begin
      runCycle();
      checkOutput("stall_allow_3", ifc.allow_3, 1'b0);
      checkOutput("stall_pc", ifc.stage_3_to_4[31:0], 32'h0000_0100);
      checkOutput("stall_en", ifc.data_sram_en, 1'b0);
    end
    iAllow4 = 1;
    applyStimulus();
    #1;
    checkOutput("st_en", ifc.data_sram_en, 1'b1);
    checkOutput("st_we", ifc.data_sram_we, 4'hF);
    checkOutput("st_addr", ifc.data_sram_addr, 32'h0000_2008);
    checkOutput("st_wdata", ifc.data_sram_wdata, 32'hDEAD_BEEF);
    runCycle();
    iValid2 = 0;
    runCycle();
    checkOutput("st_en_once", enCount, 1);

    // 5: back-to-back instructions with no stall
    iValid2 = 1; iAllow4 = 1;
    for (int k = 0; k < 4; k++) begin
      setInstr(1, 5'(k + 10), 32'(k), 32'h10, 6, 0, 0, 32'h0000_0200 + 32'(4 * k), 0);
      runCycle();
      checkOutput("b2b_pc", ifc.stage_3_to_4[31:0], 32'h0000_0200 + 32'(4 * k));
      checkOutput("b2b_valid", ifc.valid_3, 1'b1);
    end

    // 6: branch without writeback, then reset during a stall
    setInstr(0, 3, 32'h5, 32'h5, 1, 0, 0, 32'h0000_0300, 0);
    runCycle();
    checkOutput("branch_fwd", ifc.rf_waddr_3_fwd, 5'd0);
    setInstr(1, 9, 32'h0000_4000, 32'h4, 0, 0, 1, 32'h0000_0304, 0);
    runCycle();
    iAllow4 = 0;
    setInstr(1, 2, 32'h0, 32'h0, 0, 0, 0, 32'h0000_0308, 0);
    runCycle();
    checkOutput("pre_rst_valid", ifc.valid_3, 1'b1);
    iReset = 1;
    runCycle();
    iReset = 0; iValid2 = 0; iAllow4 = 1;
    applyStimulus();
    #1;
    checkOutput("midstall_rst_valid", ifc.valid_3, 1'b0);
    checkOutput("midstall_rst_en", ifc.data_sram_en, 1'b0);
    runCycle();

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      iReset  = ($urandom_range(0, 39) == 0);
      iValid2 = ($urandom_range(0, 3) != 0);
      iAllow4 = ($urandom_range(0, 3) != 0);
      setInstr(1'($urandom_range(0, 1)), 5'($urandom), $urandom, $urandom,
               int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom, $urandom);
      runCycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
